core_redirect_ctrl: RTL and testbench

Sequences every change of control flow for the core front end. It takes the branch unit's taken-branch pulse and halfword target, then asserts a pipeline flush for a fixed number of cycles. It then presents a redirect to fetch under a ready handshake, and discards fetch responses belonging to requests issued before the redirect was accepted. It sits between the branch unit (producer of branch/target) and the fetch/decode/issue stages (consumers of flush/redirect/discard).

---
 rtl/core_redirect_ctrl.sv | 106 ++++++++++
 tb/tb_core_redirect_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/core_redirect_ctrl.sv
// core_redirect_ctrl: sequences front-end control-flow changes.
// A taken branch triggers a fixed-length flush, then a redirect offered to
// fetch under a ready handshake. Fetch responses to requests issued before
// the redirect was accepted are flagged as stale so fetch can drop them.
module core_redirect_ctrl #(
  parameter int PTR_W           = 31,
  parameter int FLUSH_CYCLES    = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_in,
  input  logic [PTR_W-1:0] target_in,
  input  logic             fetch_ready,
  input  logic             fetch_req,
  input  logic             fetch_rsp,
  output logic             fetch_redirect,
  output logic [PTR_W-1:0] fetch_target,
  output logic             flush,
  output logic             issue_hold,
  output logic             rsp_discard
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [FC_W-1:0]  flush_cnt;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] stale;
  logic             accept;
  logic             capture;
  logic             cnt_inc;
  logic             cnt_dec;

  assign accept  = (state == REDIRECT) && fetch_ready;
  assign capture = (state == IDLE) && branch_in;
  // Saturate rather than wrap if fetch breaks the outstanding-request protocol.
  assign cnt_inc = fetch_req && !fetch_rsp && (outstanding != CNT_W'(MAX_OUTSTANDING));
  assign cnt_dec = fetch_rsp && !fetch_req && (outstanding != '0);

  // State register; reset lands in REDIRECT so fetch starts at the reset vector.
  always_ff @(posedge clk) begin
    if (rst) state <= REDIRECT;
    else     state <= next_state;
  end

  // Next-state logic: branches outside IDLE are wrong-path and ignored.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (branch_in) next_state = FLUSH;
      FLUSH:    if (flush_cnt == '0) next_state = REDIRECT;
      REDIRECT: if (fetch_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Output decode; any response while not IDLE belongs to the wrong path.
  always_comb begin
    flush          = (state == FLUSH) || (state == REDIRECT);
    issue_hold     = (state != IDLE);
    fetch_redirect = (state == REDIRECT);
    rsp_discard    = fetch_rsp && ((state != IDLE) || (stale != '0));
  end

  // Redirect target is captured only on an accepted branch or cleared by reset.
  always_ff @(posedge clk) begin
    if (rst)          fetch_target <= '0;
    else if (capture) fetch_target <= target_in;
  end

  // Flush length counter, loaded so FLUSH lasts exactly FLUSH_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst)                                    flush_cnt <= '0;
    else if (capture)                           flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
    else if (state == FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - FC_W'(1);
  end

  // Requests in flight at fetch.
  always_ff @(posedge clk) begin
    if (rst)          outstanding <= '0;
    else if (cnt_inc) outstanding <= outstanding + CNT_W'(1);
    else if (cnt_dec) outstanding <= outstanding - CNT_W'(1);
  end

  // Stale responses still to drop; a request in the accept cycle is post-redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      stale <= '0;
    end else if (accept) begin
      if (fetch_rsp && outstanding != '0) stale <= outstanding - CNT_W'(1);
      else                                stale <= outstanding;
    end else if (state == IDLE && fetch_rsp && stale != '0) begin
      stale <= stale - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_core_redirect_ctrl.sv
// Directed, scoreboarded bench for core_redirect_ctrl.
module tb_core_redirect_ctrl;

  localparam int PTR_W   = 31;
  localparam int MAX_OUT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             branch_in;
  logic [PTR_W-1:0] target_in;
  logic             fetch_ready;
  logic             fetch_req;
  logic             fetch_rsp;
  logic             fetch_redirect;
  logic [PTR_W-1:0] fetch_target;
  logic             flush;
  logic             issue_hold;
  logic             rsp_discard;

  typedef struct {
    string            tag;
    logic             flush;
    logic             hold;
    logic             redir;
    logic [PTR_W-1:0] target;
    logic             disc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   tb_out = 0;

  core_redirect_ctrl #(
    .PTR_W(PTR_W),
    .FLUSH_CYCLES(2),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .branch_in(branch_in),
    .target_in(target_in),
    .fetch_ready(fetch_ready),
    .fetch_req(fetch_req),
    .fetch_rsp(fetch_rsp),
    .fetch_redirect(fetch_redirect),
    .fetch_target(fetch_target),
    .flush(flush),
    .issue_hold(issue_hold),
    .rsp_discard(rsp_discard)
  );

  always #5 clk = ~clk;

  // Pop the expectation for this cycle and compare away from the clock edge.
  task automatic checkOutput();
    exp_t e;
    @(negedge clk);
    e = sb.pop_front();
    total++;
    assert (flush === e.flush) else begin
      bad++;
      $error("[TB] FAIL %s flush got=%0b exp=%0b", e.tag, flush, e.flush);
    end
    total++;
    assert (issue_hold === e.hold) else begin
      bad++;
      $error("[TB] FAIL %s issue_hold got=%0b exp=%0b", e.tag, issue_hold, e.hold);
    end
    total++;
    assert (fetch_redirect === e.redir) else begin
      bad++;
      $error("[TB] FAIL %s fetch_redirect got=%0b exp=%0b", e.tag, fetch_redirect, e.redir);
    end
    total++;
    assert (fetch_target === e.target) else begin
      bad++;
      $error("[TB] FAIL %s fetch_target got=%0h exp=%0h", e.tag, fetch_target, e.target);
    end
    total++;
    assert (rsp_discard === e.disc) else begin
      bad++;
      $error("[TB] FAIL %s rsp_discard got=%0b exp=%0b", e.tag, rsp_discard, e.disc);
    end
  endtask

  // Drive one cycle of inputs, queue its expected outputs, then advance.
  task automatic applyStimulus(
    input string            tag,
    input logic             r,
    input logic             b,
    input logic [PTR_W-1:0] t,
    input logic             rdy,
    input logic             rq,
    input logic             rs,
    input logic             ef,
    input logic             eh,
    input logic             er,
    input logic [PTR_W-1:0] et,
    input logic             ed
  );
    exp_t e;
    e.tag = tag; e.flush = ef; e.hold = eh; e.redir = er; e.target = et; e.disc = ed;
    sb.push_back(e);
    if (!r && ((rq && !rs && tb_out == MAX_OUT) || (rs && tb_out == 0))) begin
      bad++;
      $display("[TB] FAIL %s protocol outstanding=%0d req=%0b rsp=%0b", tag, tb_out, rq, rs);
    end
    rst = r; branch_in = b; target_in = t;
    fetch_ready = rdy; fetch_req = rq; fetch_rsp = rs;
    checkOutput();
    @(posedge clk);
    #1;
    if (r) tb_out = 0;
    else   tb_out = tb_out + int'(rq) - int'(rs);
  endtask

  initial begin
    rst = 1'b1; branch_in = 1'b0; target_in = '0;
    fetch_ready = 1'b1; fetch_req = 1'b0; fetch_rsp = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset: redirect to vector 0, accepted immediately.
    applyStimulus("rst_redir", 0, 0, 0,     1, 0, 0, 1, 1, 1, 31'h0,   0);
    applyStimulus("rst_idle",  0, 0, 0,     0, 0, 0, 0, 0, 0, 31'h0,   0);

    // Basic branch with ready high.
    applyStimulus("br_b",      0, 1, 31'h100, 1, 0, 0, 0, 0, 0, 31'h0,   0);
    applyStimulus("br_f1",     0, 0, 0,       1, 0, 0, 1, 1, 0, 31'h100, 0);
    applyStimulus("br_f2",     0, 0, 0,       1, 0, 0, 1, 1, 0, 31'h100, 0);
    applyStimulus("br_redir",  0, 0, 0,       1, 0, 0, 1, 1, 1, 31'h100, 0);
    applyStimulus("br_idle",   0, 0, 0,       1, 0, 0, 0, 0, 0, 31'h100, 0);

    // Backpressure: five cycles of ready low in REDIRECT.
    applyStimulus("bp_b",      0, 1, 31'h2A0, 0, 0, 0, 0, 0, 0, 31'h100, 0);
    applyStimulus("bp_f1",     0, 0, 0,       0, 0, 0, 1, 1, 0, 31'h2A0, 0);
    applyStimulus("bp_f2",     0, 0, 0,       0, 0, 0, 1, 1, 0, 31'h2A0, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus("bp_wait", 0, 0, 0,       0, 0, 0, 1, 1, 1, 31'h2A0, 0);
    applyStimulus("bp_acc",    0, 0, 0,       1, 0, 0, 1, 1, 1, 31'h2A0, 0);
    applyStimulus("bp_idle",   0, 0, 0,       0, 0, 0, 0, 0, 0, 31'h2A0, 0);

    // Stale drain: three in flight, one returns during FLUSH, two stale left.
    applyStimulus("st_q0",     0, 0, 0,       0, 1, 0, 0, 0, 0, 31'h2A0, 0);
    applyStimulus("st_q1",     0, 0, 0,       0, 1, 0, 0, 0, 0, 31'h2A0, 0);
    applyStimulus("st_q2",     0, 0, 0,       0, 1, 0, 0, 0, 0, 31'h2A0, 0);
    applyStimulus("st_b",      0, 1, 31'h300, 0, 0, 0, 0, 0, 0, 31'h2A0, 0);
    applyStimulus("st_f1rsp",  0, 0, 0,       0, 0, 1, 1, 1, 0, 31'h300, 1);
    applyStimulus("st_f2",     0, 0, 0,       0, 0, 0, 1, 1, 0, 31'h300, 0);
    applyStimulus("st_acc",    0, 0, 0,       1, 0, 0, 1, 1, 1, 31'h300, 0);
    applyStimulus("st_d0",     0, 0, 0,       0, 0, 1, 0, 0, 0, 31'h300, 1);
    applyStimulus("st_d1",     0, 0, 0,       0, 0, 1, 0, 0, 0, 31'h300, 1);
    applyStimulus("st_q3",     0, 0, 0,       0, 1, 0, 0, 0, 0, 31'h300, 0);
    applyStimulus("st_d2",     0, 0, 0,       0, 0, 1, 0, 0, 0, 31'h300, 0);

    // Accept-cycle corner: rsp and req together in the acceptance cycle.
    applyStimulus("ac_q0",     0, 0, 0,       0, 1, 0, 0, 0, 0, 31'h300, 0);
    applyStimulus("ac_q1",     0, 0, 0,       0, 1, 0, 0, 0, 0, 31'h300, 0);
    applyStimulus("ac_b",      0, 1, 31'h400, 0, 0, 0, 0, 0, 0, 31'h300, 0);
    applyStimulus("ac_f1",     0, 0, 0,       0, 0, 0, 1, 1, 0, 31'h400, 0);
    applyStimulus("ac_f2",     0, 0, 0,       0, 0, 0, 1, 1, 0, 31'h400, 0);
    applyStimulus("ac_acc",    0, 0, 0,       1, 1, 1, 1, 1, 1, 31'h400, 1);
    applyStimulus("ac_d0",     0, 0, 0,       0, 0, 1, 0, 0, 0, 31'h400, 1);
    applyStimulus("ac_d1",     0, 0, 0,       0, 0, 1, 0, 0, 0, 31'h400, 0);

    // Wrong-path branch during FLUSH, then reset while in REDIRECT.
    applyStimulus("ig_b",      0, 1, 31'h500, 0, 0, 0, 0, 0, 0, 31'h400, 0);
    applyStimulus("ig_f1",     0, 1, 31'h40,  0, 1, 0, 1, 1, 0, 31'h500, 0);
    applyStimulus("ig_f2",     0, 0, 0,       0, 1, 0, 1, 1, 0, 31'h500, 0);
    applyStimulus("ig_rst",    1, 0, 0,       0, 0, 0, 1, 1, 1, 31'h500, 0);
    applyStimulus("mr_redir",  0, 0, 0,       1, 0, 0, 1, 1, 1, 31'h0,   0);
    applyStimulus("mr_q0",     0, 0, 0,       0, 1, 0, 0, 0, 0, 31'h0,   0);
    applyStimulus("mr_rsp",    0, 0, 0,       0, 0, 1, 0, 0, 0, 31'h0,   0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
